rf_op_sequencer: RTL and testbench
==================================

// Module: rf_op_sequencer
// PURPOSE
//  Multi-cycle operand-fetch / write-back sequencer sitting directly upstream of the 16x8 register file.
//  Drives the register file's single addr/read/write port: fetches source operand A, then optionally B.
//  Holds both operands for the combinational ALU, captures the result and optionally writes it back.
//  One instruction is in flight at a time; start/ready handshake toward the control unit.
// PARAMETERS
//  DATA_W   8  register / operand width
//  ADDR_W   8  width of register-file addr port; only low SEL_W bits are significant
//  SEL_W    4  register select width (16 registers)
// PORTS
//  clk       in   1        single clock; all state changes on posedge
//  rst       in   1        synchronous, active-high reset
//  start     in   1        request; accepted only in a cycle where ready=1
//  rs1       in   SEL_W    source register A, sampled on accept
//  rs2       in   SEL_W    source register B, sampled on accept
//  rd        in   SEL_W    destination register, sampled on accept
//  use_rs2   in   1        1: fetch B from rs2; 0: opb forced to 0, RD2 skipped
//  wb_en     in   1        1: write result to rd; 0: result only held in res
//  ready     out  1        high only in IDLE
//  done      out  1        one-cycle pulse in the final cycle of an instruction
//  opa       out  DATA_W   latched operand A (to ALU)
//  opb       out  DATA_W   latched operand B (to ALU)
//  alu_y     in   DATA_W   combinational ALU result of opa/opb
//  res       out  DATA_W   latched ALU result
//  rf_addr   out  ADDR_W   register-file address, upper ADDR_W-SEL_W bits always 0
//  rf_read   out  1        register-file read enable
//  rf_write  out  1        register-file write enable
//  rf_wdata  out  DATA_W   register-file write data (= res)
//  rf_rdata  in   DATA_W   register-file read data (high-Z when rf_read=0)
// BEHAVIOUR
//  - States: IDLE, RD1, RD2, EXEC, WB. All outputs except opa/opb/res are Moore decodes of state.
//  - IDLE: ready=1, rf_addr=0, rf_read=rf_write=done=0. start=1 -> latch rs1/rs2/rd/use_rs2/wb_en, go RD1.
//  - RD1: rf_read=1, rf_addr=rs1; opa<=rf_rdata at edge. Next RD2 if use_rs2, else EXEC with opb<=0.
//  - RD2: rf_read=1, rf_addr=rs2; opb<=rf_rdata at edge. Next EXEC.
//  - EXEC: no RF access; res<=alu_y at edge. If wb_en: next WB, done=0. Else: done=1, next IDLE.
//  - WB: rf_write=1, rf_addr=rd, rf_wdata=res, done=1; next IDLE.
//  - rf_rdata sampled only when rf_read=1; never sample Z. rf_read and rf_write never both high.
//  - Latency (accept edge = cycle 0): full op done in cycle 4, ready again cycle 5.
//    Other latencies: no rs2 -> done in cycle 3; no wb -> done in cycle 3; neither -> done in cycle 2.
//  - start while ready=0 ignored, not queued. Inputs other than start/alu_y/rf_rdata are don't-care outside accept.
//  - rd may equal rs1/rs2. The write lands at the WB edge; the next instruction's RD1 reads the new value (no hazard).
//  - Reset: state->IDLE, opa=opb=res=0, latched fields=0. Reset values of outputs: ready=1, all other outputs 0.
//  - Reset mid-op: abort at that edge. Because outputs are state-decoded, a rst asserted during a WB cycle
//    still commits that write (RF samples same edge). This is intended.
//  - All values unsigned DATA_W; no width extension or truncation inside this block.
// TESTING
//  1. Full op: preload R3=8'h12,R5=8'h34; start rs1=3,rs2=5,rd=7,alu_y=opa+opb -> done cycle 4, R7=8'h46, ready cycle 5.
//  2. use_rs2=0: R2=8'hA5, rs1=2, rd=9, alu_y=opa -> opb=0, done cycle 3, R9=8'hA5; no read of rs2 observed.
//  3. wb_en=0: rs1=1,rs2=1 -> done cycle 3, res valid, rf_write never asserted, R[rd] unchanged.
//  4. Back-to-back + RAW: op1 writes R4=8'h77, start held high -> op2 rs1=4 accepted cycle 5, opa=8'h77.
//  5. start pulsed during RD2 -> ignored, no second done, ready stays 0 until cycle 5.
//  6. rst in RD2 -> next cycle IDLE, opa=opb=res=0, ready=1; rst in WB -> write still lands, then IDLE.

Source files
------------

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: multi-cycle operand-fetch / execute / write-back sequencer
// in front of a 16x8 single-port register file. It handles one instruction at a time.
//   clk, rst                  clock, synchronous active-high reset
//   start/ready               instruction request / IDLE indication
//   rs1, rs2, rd              source A, source B, destination select (captured on accept)
//   use_rs2, wb_en            fetch B enable, write-back enable (captured on accept)
//   done                      pulse in the final cycle of an instruction
//   opa, opb, alu_y, res      operands to the ALU, ALU result in, latched result
//   rf_addr/read/write/wdata  register-file port (driven by this block)
//   rf_rdata                  register-file read data (only sampled while rf_read=1)
module rf_op_sequencer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned SEL_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEL_W-1:0]  rs1,
   input  logic [SEL_W-1:0]  rs2,
   input  logic [SEL_W-1:0]  rd,
   input  logic              use_rs2,
   input  logic              wb_en,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] opa,
   output logic [DATA_W-1:0] opb,
   input  logic [DATA_W-1:0] alu_y,
   output logic [DATA_W-1:0] res,
   output logic [ADDR_W-1:0] rf_addr,
   output logic              rf_read,
   output logic              rf_write,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD1  = 3'd1,
      S_RD2  = 3'd2,
      S_EXEC = 3'd3,
      S_WB   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [SEL_W-1:0] rs1_q;
   logic [SEL_W-1:0] rs2_q;
   logic [SEL_W-1:0] rd_q;
   logic             use_rs2_q;
   logic             wb_en_q;

   logic             ready_nxt;
   logic             done_nxt;
   logic             rf_read_nxt;
   logic             rf_write_nxt;
   logic [SEL_W-1:0] sel_nxt;

   // Next state plus the state decodes for the state being entered. Registering
   // the decode of state_nxt gives the same waveform as a Moore decode of state.
   always_comb begin
      state_nxt    = state;
      ready_nxt    = 1'b0;
      done_nxt     = 1'b0;
      rf_read_nxt  = 1'b0;
      rf_write_nxt = 1'b0;
      sel_nxt      = '0;

      case (state)
         S_IDLE: if (start) state_nxt = S_RD1;
         S_RD1:  state_nxt = use_rs2_q ? S_RD2 : S_EXEC;
         S_RD2:  state_nxt = S_EXEC;
         S_EXEC: state_nxt = wb_en_q ? S_WB : S_IDLE;
         S_WB:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      case (state_nxt)
         S_IDLE: ready_nxt = 1'b1;
         S_RD1: begin
            // RD1 is only entered from IDLE on accept, so rs1 comes straight from the port
            rf_read_nxt = 1'b1;
            sel_nxt     = rs1;
         end
         S_RD2: begin
            rf_read_nxt = 1'b1;
            sel_nxt     = rs2_q;
         end
         // EXEC is the final cycle only when there is no write-back
         S_EXEC: done_nxt = ~wb_en_q;
         S_WB: begin
            rf_write_nxt = 1'b1;
            done_nxt     = 1'b1;
            sel_nxt      = rd_q;
         end
         default: ready_nxt = 1'b0;
      endcase
   end

   // State register and registered port decodes
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ready    <= 1'b1;
         done     <= 1'b0;
         rf_read  <= 1'b0;
         rf_write <= 1'b0;
         rf_addr  <= '0;
      end else begin
         state    <= state_nxt;
         ready    <= ready_nxt;
         done     <= done_nxt;
         rf_read  <= rf_read_nxt;
         rf_write <= rf_write_nxt;
         rf_addr  <= ADDR_W'(sel_nxt);
      end
   end

   // Instruction fields, operands and result
   always_ff @(posedge clk) begin
      if (rst) begin
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         use_rs2_q <= 1'b0;
         wb_en_q   <= 1'b0;
         opa       <= '0;
         opb       <= '0;
         res       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  rs1_q     <= rs1;
                  rs2_q     <= rs2;
                  rd_q      <= rd;
                  use_rs2_q <= use_rs2;
                  wb_en_q   <= wb_en;
               end
            end
            S_RD1: begin
               opa <= rf_rdata;
               if (!use_rs2_q) opb <= '0;
            end
            S_RD2:  opb <= rf_rdata;
            S_EXEC: res <= alu_y;
            default: ;
         endcase
      end
   end

   assign rf_wdata = res;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: a behavioural register file and ALU surround the DUT;
// a reference register array plus per-instruction timing rules give expected values.
module tb_rf_op_sequencer;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned SEL_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [SEL_W-1:0]  rs1, rs2, rd;
   logic              use_rs2, wb_en;
   logic              ready, done;
   logic [DATA_W-1:0] opa, opb, alu_y, res;
   logic [ADDR_W-1:0] rf_addr;
   logic              rf_read, rf_write;
   logic [DATA_W-1:0] rf_wdata;
   wire  [DATA_W-1:0] rf_rdata;

   logic [DATA_W-1:0] rf_mem [16];
   logic [DATA_W-1:0] model_rf [16];
   logic              pre_we;
   logic [SEL_W-1:0]  pre_addr;
   logic [DATA_W-1:0] pre_data;
   logic [1:0]        alu_sel;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
      .use_rs2(use_rs2), .wb_en(wb_en), .ready(ready), .done(done),
      .opa(opa), .opb(opb), .alu_y(alu_y), .res(res), .rf_addr(rf_addr),
      .rf_read(rf_read), .rf_write(rf_write), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
   );

   function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [1:0] s);
      case (s)
         2'd0:    return a + b;
         2'd1:    return a ^ b;
         2'd2:    return a;
         default: return a - b;
      endcase
   endfunction

   // Register file: write port from the DUT, side preload port from the bench
   always @(posedge clk) begin
      if (rf_write) rf_mem[rf_addr[SEL_W-1:0]] <= rf_wdata;
      else if (pre_we) rf_mem[pre_addr] <= pre_data;
   end
   assign rf_rdata = rf_read ? rf_mem[rf_addr[SEL_W-1:0]] : 'z;
   assign alu_y = alu_f(opa, opb, alu_sel);

   task automatic preload(input logic [SEL_W-1:0] a, input logic [DATA_W-1:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
      model_rf[a] = d;
   endtask

   // Issue one instruction and check every cycle until ready returns.
   task automatic run_op(input logic [SEL_W-1:0] a1, input logic [SEL_W-1:0] a2,
                         input logic [SEL_W-1:0] d, input logic u, input logic w,
                         input logic [1:0] s, input logic keep_start, input int pulse_at,
                         output int waited);
      logic [DATA_W-1:0] ea, eb, er;
      logic [11:0] got, exp;
      logic erd, ewr, edone;
      logic [SEL_W-1:0] eaddr;
      int dc;
      ea = model_rf[a1];
      eb = u ? model_rf[a2] : 8'h00;
      er = alu_f(ea, eb, s);
      dc = 2 + int'(u) + int'(w);
      rs1 = a1; rs2 = a2; rd = d; use_rs2 = u; wb_en = w; alu_sel = s;
      start = 1'b1;
      waited = 0;
      while (ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      vectors++;
      if (ready !== 1'b1) begin
         $display("FAIL accept_wait: ready=%b required 1 within 20 cycles", ready);
         miscompares++;
         start = 1'b0;
         return;
      end
      @(posedge clk); #1;
      for (int c = 1; c <= dc; c++) begin
         erd   = (c == 1) || (u && c == 2);
         ewr   = w && (c == dc);
         edone = (c == dc);
         eaddr = (c == 1) ? a1 : (u && c == 2) ? a2 : ewr ? d : '0;
         got = {ready, done, rf_read, rf_write, rf_addr};
         exp = {1'b0, edone, erd, ewr, ADDR_W'(eaddr)};
         vectors++;
         if (got !== exp) begin
            $display("FAIL cycle%0d ctrl {ready,done,rd,wr,addr}: got %h required %h", c, got, exp);
            miscompares++;
         end
         if (ewr) begin
            vectors++;
            if (rf_wdata !== er) begin
               $display("FAIL wb_data: got %h required %h", rf_wdata, er);
               miscompares++;
            end
         end
         if (c == dc) begin
            vectors++;
            if ({opa, opb} !== {ea, eb}) begin
               $display("FAIL operands: got opa=%h opb=%h required opa=%h opb=%h", opa, opb, ea, eb);
               miscompares++;
            end
         end
         start = (c == pulse_at) ? 1'b1 : keep_start;
         if (c < dc) begin
            @(posedge clk); #1;
         end
      end
      if (w) model_rf[d] = er;
      @(posedge clk); #1;
      vectors++;
      if ({ready, done, res} !== {1'b1, 1'b0, er}) begin
         $display("FAIL after_done {ready,done,res}: got %b %b %h required 1 0 %h", ready, done, res, er);
         miscompares++;
      end
      vectors++;
      if (rf_mem[d] !== model_rf[d]) begin
         $display("FAIL rf_dest R%0d: got %h required %h", d, rf_mem[d], model_rf[d]);
         miscompares++;
      end
   endtask

   task automatic check_idle(input string name);
      vectors++;
      if ({ready, done, rf_read, rf_write, rf_addr, opa, opb, res, rf_wdata} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}) begin
         $display("FAIL %s: ready=%b done=%b rd=%b wr=%b addr=%h opa=%h opb=%h res=%h wdata=%h required idle/zero",
                  name, ready, done, rf_read, rf_write, rf_addr, opa, opb, res, rf_wdata);
         miscompares++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      rs1 = '0; rs2 = '0; rd = '0; use_rs2 = 1'b0; wb_en = 1'b0; alu_sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset_state");
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("post_reset_idle");
      for (int i = 0; i < 16; i++) preload(SEL_W'(i), 8'h00);
   endtask

   task automatic test_full_op();
      int wt;
      preload(4'd3, 8'h12);
      preload(4'd5, 8'h34);
      run_op(4'd3, 4'd5, 4'd7, 1'b1, 1'b1, 2'd0, 1'b0, -1, wt);
      vectors++;
      if (rf_mem[7] !== 8'h46) begin
         $display("FAIL full_op_R7: got %h required 46", rf_mem[7]);
         miscompares++;
      end
   endtask

   task automatic test_no_rs2();
      int wt;
      preload(4'd2, 8'hA5);
      preload(4'd6, 8'h3C);
      run_op(4'd2, 4'd6, 4'd9, 1'b0, 1'b1, 2'd2, 1'b0, -1, wt);
      vectors++;
      if ({rf_mem[9], opb} !== {8'hA5, 8'h00}) begin
         $display("FAIL no_rs2 {R9,opb}: got %h %h required a5 00", rf_mem[9], opb);
         miscompares++;
      end
   endtask

   task automatic test_no_wb();
      int wt;
      preload(4'd1, 8'h21);
      preload(4'd8, 8'h5A);
      run_op(4'd1, 4'd1, 4'd8, 1'b1, 1'b0, 2'd0, 1'b0, -1, wt);
      vectors++;
      if ({rf_mem[8], res} !== {8'h5A, 8'h42}) begin
         $display("FAIL no_wb {R8,res}: got %h %h required 5a 42", rf_mem[8], res);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      int wt;
      preload(4'd1, 8'h70);
      preload(4'd2, 8'h07);
      run_op(4'd1, 4'd2, 4'd4, 1'b1, 1'b1, 2'd0, 1'b1, -1, wt);
      run_op(4'd4, 4'd0, 4'd10, 1'b0, 1'b1, 2'd2, 1'b0, -1, wt);
      vectors++;
      if (wt != 0 || opa !== 8'h77 || rf_mem[10] !== 8'h77) begin
         $display("FAIL back_to_back: wait=%0d opa=%h R10=%h required wait=0 opa=77 R10=77", wt, opa, rf_mem[10]);
         miscompares++;
      end
   endtask

   task automatic test_start_ignored();
      int wt;
      run_op(4'd3, 4'd5, 4'd12, 1'b1, 1'b1, 2'd1, 1'b0, 2, wt);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vectors++;
         if ({ready, done, rf_read} !== 3'b100) begin
            $display("FAIL start_ignored_idle%0d {ready,done,rd}: got %b required 100", i, {ready, done, rf_read});
            miscompares++;
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [DATA_W-1:0] er;
      // abort during RD2: nothing written, datapath cleared
      rs1 = 4'd3; rs2 = 4'd5; rd = 4'd6; use_rs2 = 1'b1; wb_en = 1'b1; alu_sel = 2'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({rf_read, rf_addr} !== {1'b1, 8'h05}) begin
         $display("FAIL rst_rd2_pre {rd,addr}: got %b %h required 1 05", rf_read, rf_addr);
         miscompares++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle("rst_in_rd2");
      @(posedge clk); #1;
      check_idle("rst_in_rd2_hold");
      vectors++;
      if (rf_mem[6] !== model_rf[6]) begin
         $display("FAIL rst_rd2_R6: got %h required %h", rf_mem[6], model_rf[6]);
         miscompares++;
      end
      // reset in the WB cycle: the write still lands
      er = model_rf[3] + model_rf[5];
      rs1 = 4'd3; rs2 = 4'd5; rd = 4'd11;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({done, rf_write, rf_addr} !== {1'b1, 1'b1, 8'h0B}) begin
         $display("FAIL rst_wb_pre {done,wr,addr}: got %b %b %h required 1 1 0b", done, rf_write, rf_addr);
         miscompares++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_rf[11] = er;
      check_idle("rst_in_wb");
      vectors++;
      if (rf_mem[11] !== er) begin
         $display("FAIL rst_wb_R11: got %h required %h", rf_mem[11], er);
         miscompares++;
      end
   endtask

   task automatic test_random();
      int wt;
      for (int i = 0; i < 16; i++) preload(SEL_W'(i), 8'($urandom));
      for (int n = 0; n < 40; n++) begin
         run_op(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), 1'($urandom), -1, wt);
      end
      start = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (rf_mem[i] !== model_rf[i]) begin
            $display("FAIL random_rf R%0d: got %h required %h", i, rf_mem[i], model_rf[i]);
            miscompares++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_op();
      test_no_rs2();
      test_no_wb();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
